// File: rtl/spi_rx_byte_assembler.sv
// SPI mode-0 slave receive path on the system clock: synchronizes the raw SPI pins,
// assembles MSB-first words and queues them in a small valid/ready FIFO.
module spi_rx_byte_assembler #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_mosi_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              overflow_o,
  input  logic              clr_err_i
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_s, mosi_s, sclk_rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-2:0]      shreg_q, shreg_d;
  logic                   frame_err_q, frame_err_d;
  logic                   push;
  logic [DATA_W-1:0]      shifted;

  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr_q, rd_ptr_q;
  logic                   overflow_q, overflow_d;
  logic                   empty, full, pop, wr_en;

  // Synchronizer chains reset to the idle bus levels so no false edge appears after reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign shifted   = {shreg_q, mosi_s};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_MAX;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  // A chip-select release takes priority over an SCLK edge seen in the same cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d = SHIFT;
          cnt_d   = CNT_MAX;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_d     = IDLE;
          frame_err_d = (cnt_q != CNT_MAX);
          cnt_d       = CNT_MAX;
          shreg_d     = '0;
        end else if (sclk_rise) begin
          shreg_d = shifted[DATA_W-2:0];
          if (cnt_q == '0) begin
            push  = 1'b1;
            cnt_d = CNT_MAX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop   = ~empty & rx_ready_i;
  assign wr_en = push & (~full | pop);

  // Set beats clear so a drop in the clearing cycle is never lost
  always_comb begin
    overflow_d = overflow_q;
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end else if (clr_err_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= shifted;
    end
  end

  assign rx_data_o   = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];
  assign rx_valid_o  = ~empty;
  assign busy_o      = (state_q == SHIFT);
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_spi_rx_byte_assembler.sv
// Scoreboard bench for spi_rx_byte_assembler: words expected by the bench are queued
// when sent and compared as the consumer pops them.
module tb_spi_rx_byte_assembler;

   localparam int DATA_W = 8;
   localparam int HALF   = 4;

   logic              clock = 1'b0;
   logic              rst   = 1'b1;
   logic              sclk  = 1'b0;
   logic              csN   = 1'b1;
   logic              mosi  = 1'b0;
   logic              ready = 1'b0;
   logic              clrErr = 1'b0;
   logic [DATA_W-1:0] rxData;
   logic              rxValid, busy, frameErr, overflow;

   int                total = 0;
   int                bad   = 0;
   logic [DATA_W-1:0] sbQueue [$];
   int                validCycles    = 0;
   int                frameErrCycles = 0;
   int                frameErrPulses = 0;
   logic              frameErrPrev   = 1'b0;

   spi_rx_byte_assembler #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
      .clk_i       (clock),
      .rst_i       (rst),
      .spi_sclk_i  (sclk),
      .spi_cs_n_i  (csN),
      .spi_mosi_i  (mosi),
      .rx_data_o   (rxData),
      .rx_valid_o  (rxValid),
      .rx_ready_i  (ready),
      .busy_o      (busy),
      .frame_err_o (frameErr),
      .overflow_o  (overflow),
      .clr_err_i   (clrErr)
   );

   // Free-running system clock, 10 time units per period
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, observed, expected);
      end
   endtask

   // Waits n rising edges, leaving time just past the last edge so inputs change away from it
   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // One SCLK period; optionally holds ready for exactly the cycle in which the bit gets shifted
   task automatic sendBit(input logic b, input bit popOnShift);
      mosi = b;
      waitCycles(HALF);
      sclk = 1'b1;
      if (popOnShift) begin
         waitCycles(2);
         ready = 1'b1;
         waitCycles(1);
         ready = 1'b0;
         waitCycles(HALF - 3);
      end else begin
         waitCycles(HALF);
      end
      sclk = 1'b0;
   endtask

   task automatic sendBits(input logic [DATA_W-1:0] w, input int nBits, input bit popOnLast);
      for (int i = DATA_W - 1; i >= DATA_W - nBits; i--) begin
         sendBit(w[i], popOnLast && (i == 0));
      end
   endtask

   // Sends one full word; the scoreboard only expects it when the FIFO will accept it
   task automatic applyStimulus(input logic [DATA_W-1:0] w, input bit expectAccepted, input bit popOnLast);
      if (expectAccepted) sbQueue.push_back(w);
      sendBits(w, DATA_W, popOnLast);
   endtask

   task automatic csLow();
      csN = 1'b0;
      waitCycles(6);
   endtask

   task automatic csHigh();
      waitCycles(6);
      csN = 1'b1;
      waitCycles(6);
   endtask

   // Lets the consumer drain everything the scoreboard still expects, within a cycle budget
   task automatic drain();
      int budget;
      budget = 60;
      ready = 1'b1;
      while (sbQueue.size() != 0 && budget > 0) begin
         waitCycles(1);
         budget--;
      end
      checkOutput("drain_queue_left", 32'(sbQueue.size()), 0);
      waitCycles(2);
   endtask

   // Monitor sampled on the falling edge, well away from the active edge
   always @(negedge clock) begin
      if (!rst) begin
         if (rxValid) validCycles++;
         if (frameErr) frameErrCycles++;
         if (frameErr && !frameErrPrev) frameErrPulses++;
         frameErrPrev = frameErr;
         if (rxValid && ready) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected_pop", 32'(rxValid), 0);
            end else begin
               checkOutput("sb_word", 32'(rxData), 32'(sbQueue.pop_front()));
            end
         end
      end
   end

   initial begin
      int v0;
      int fe0;

      // Reset values
      waitCycles(3);
      rst = 1'b0;
      checkOutput("rst_valid", 32'(rxValid), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_frame_err", 32'(frameErr), 0);
      checkOutput("rst_overflow", 32'(overflow), 0);
      checkOutput("rst_data", 32'(rxData), 0);

      // Single word 0xA5 with the consumer always ready
      $display("[TB] single word");
      ready = 1'b1;
      csLow();
      checkOutput("busy_in_frame", 32'(busy), 1);
      v0 = validCycles;
      applyStimulus(8'hA5, 1'b1, 1'b0);
      waitCycles(3);
      checkOutput("a5_valid_cycles", 32'(validCycles - v0), 1);
      checkOutput("busy_before_cs_high", 32'(busy), 1);
      csHigh();
      checkOutput("busy_after_cs_high", 32'(busy), 0);
      checkOutput("a5_no_frame_err", 32'(frameErrPulses), 0);
      checkOutput("a5_sb_empty", 32'(sbQueue.size()), 0);

      // Four back-to-back words queued, then drained in order
      $display("[TB] four queued words");
      ready = 1'b0;
      csLow();
      applyStimulus(8'h3C, 1'b1, 1'b0);
      applyStimulus(8'hC3, 1'b1, 1'b0);
      applyStimulus(8'hFF, 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b1, 1'b0);
      csHigh();
      checkOutput("q4_valid", 32'(rxValid), 1);
      checkOutput("q4_head", 32'(rxData), 32'h3C);
      waitCycles(5);
      checkOutput("q4_head_stable", 32'(rxData), 32'h3C);
      checkOutput("q4_no_overflow", 32'(overflow), 0);
      drain();
      ready = 1'b0;
      checkOutput("q4_empty", 32'(rxValid), 0);

      // Overflow on a full FIFO, then clear
      $display("[TB] overflow");
      csLow();
      applyStimulus(8'h01, 1'b1, 1'b0);
      applyStimulus(8'h02, 1'b1, 1'b0);
      applyStimulus(8'h03, 1'b1, 1'b0);
      applyStimulus(8'h04, 1'b1, 1'b0);
      checkOutput("full_no_overflow", 32'(overflow), 0);
      applyStimulus(8'h11, 1'b0, 1'b0);
      checkOutput("overflow_set", 32'(overflow), 1);
      checkOutput("overflow_head_kept", 32'(rxData), 32'h01);
      waitCycles(3);
      checkOutput("overflow_sticky", 32'(overflow), 1);
      clrErr = 1'b1;
      waitCycles(1);
      clrErr = 1'b0;
      checkOutput("overflow_cleared", 32'(overflow), 0);

      // Push on full coinciding with a pop: accepted, no overflow
      $display("[TB] push with pop on full");
      applyStimulus(8'h22, 1'b1, 1'b1);
      waitCycles(2);
      checkOutput("pushpop_no_overflow", 32'(overflow), 0);
      checkOutput("pushpop_head", 32'(rxData), 32'h02);
      checkOutput("pushpop_sb_left", 32'(sbQueue.size()), 4);
      drain();
      ready = 1'b0;
      checkOutput("pushpop_empty", 32'(rxValid), 0);
      csHigh();

      // Partial word aborted by CS_N, then a clean frame
      $display("[TB] frame error");
      ready = 1'b1;
      fe0 = frameErrCycles;
      csLow();
      sendBits(8'hE7, 5, 1'b0);
      csHigh();
      checkOutput("frame_err_pulses", 32'(frameErrPulses), 1);
      checkOutput("frame_err_width", 32'(frameErrCycles - fe0), 1);
      checkOutput("frame_err_no_push", 32'(rxValid), 0);
      checkOutput("frame_err_busy", 32'(busy), 0);
      csLow();
      applyStimulus(8'h5A, 1'b1, 1'b0);
      csHigh();
      checkOutput("after_err_sb_empty", 32'(sbQueue.size()), 0);
      checkOutput("after_err_pulses", 32'(frameErrPulses), 1);

      // Reset mid-word with two words queued; the same frame continues afterwards
      $display("[TB] reset mid-word");
      ready = 1'b0;
      csLow();
      applyStimulus(8'h77, 1'b0, 1'b0);
      applyStimulus(8'h88, 1'b0, 1'b0);
      sendBits(8'hF0, 3, 1'b0);
      checkOutput("pre_reset_valid", 32'(rxValid), 1);
      rst = 1'b1;
      waitCycles(1);
      rst = 1'b0;
      checkOutput("post_reset_valid", 32'(rxValid), 0);
      checkOutput("post_reset_busy", 32'(busy), 0);
      waitCycles(4);
      ready = 1'b1;
      applyStimulus(8'h96, 1'b1, 1'b0);
      csHigh();
      checkOutput("post_reset_sb_empty", 32'(sbQueue.size()), 0);
      checkOutput("post_reset_no_frame_err", 32'(frameErrPulses), 1);
      checkOutput("post_reset_no_overflow", 32'(overflow), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL timeout: got running want finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
